// File: rtl/cnt_dut.sv
// cnt_dut: handshaked sequence generator.
// It accepts a count N on the input channel. It then emits 0, 1, ..., N-1 on
// the output channel, one value per transfer, and after that it accepts the
// next count.
//   clk  - single clock; all state updates on the rising edge
//   rst  - asynchronous, active-low reset
//   irdy - input valid; iint holds a count N
//   iack - input accept; only asserted in IDLE, equal to irdy there
//   iint - count N, sampled on an input transfer
//   ordy - output valid (registered); oint holds a sequence value
//   oack - output accept from the consumer
//   oint - current sequence value (registered counter)
module cnt_dut #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             irdy,
    output logic             iack,
    input  logic [WIDTH-1:0] iint,
    output logic             ordy,
    input  logic             oack,
    output logic [WIDTH-1:0] oint
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic             ordy_q,  ordy_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] limit_q, limit_d;

    logic in_xfer;
    logic out_xfer;
    logic at_last;

    // ------------------------------------------------------------------
    // Handshake logic
    // ------------------------------------------------------------------
    // iack is gated with rst so that it stays low during reset, even if the
    // source already holds irdy high.
    assign iack     = rst && (state_q == S_IDLE) && irdy;
    assign in_xfer  = iack;
    assign out_xfer = ordy_q && oack;
    // In RUN, limit_q is at least 1, so limit_q-1 cannot underflow.
    assign at_last  = (cnt_q == limit_q - WIDTH'(1));

    assign ordy = ordy_q;
    assign oint = cnt_q;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ordy_d  = ordy_q;
        case (state_q)
            S_IDLE: begin
                // A zero count is consumed without leaving IDLE.
                if (in_xfer && (iint != '0)) begin
                    state_d = S_RUN;
                    ordy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (out_xfer && at_last) begin
                    state_d = S_IDLE;
                    ordy_d  = 1'b0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter datapath
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        limit_d = limit_q;
        if (in_xfer) begin
            limit_d = iint;
            cnt_d   = '0;
        end else if (out_xfer && !at_last) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ordy_q  <= 1'b0;
            cnt_q   <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            ordy_q  <= ordy_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end

endmodule

// File: tb/tb_cnt_dut.sv
// tb_cnt_dut: directed bench for cnt_dut.
// When a count is accepted, the expected sequence values are pushed into a
// scoreboard queue. The monitor pops and compares one entry on each output
// transfer. The monitor also checks that ordy/oint stay stable while stalled
// and that iack and ordy are never high together.
module tb_cnt_dut;

    localparam int unsigned W = 11;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         irdy = 1'b0;
    logic         iack;
    logic [W-1:0] iint = '0;
    logic         ordy;
    logic         oack = 1'b0;
    logic [W-1:0] oint;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic         rand_oack = 1'b0;
    int unsigned  n_out = 0;

    cnt_dut #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .irdy(irdy),
        .iack(iack),
        .iint(iint),
        .ordy(ordy),
        .oack(oack),
        .oint(oint)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Consumer: oack is updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        oack = rand_oack ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: samples mid-cycle. Values seen here are the ones the next rising edge uses.
    logic         stall_prev = 1'b0;
    logic [W-1:0] oint_prev  = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (stall_prev) begin
                chk("stall_ordy", ordy, 1);
                chk("stall_oint", oint, oint_prev);
            end
            if (iack && ordy) chk("iack_during_ordy", 1, 0);
            if (ordy && oack) begin
                n_out++;
                if (exp_q.size() == 0) chk("spurious_output", oint, 32'hFFFF_FFFF);
                else chk("oint", oint, exp_q.pop_front());
            end
        end
        stall_prev = rst && ordy && !oack;
        oint_prev  = oint;
    end

    // Offer count n. The next sequence is queued on the accepting edge.
    // With keep=1, irdy stays high afterwards for a back-to-back request.
    task automatic send(input logic [W-1:0] n, input logic keep);
        int unsigned t = 0;
        irdy = 1'b1;
        iint = n;
        #1;
        while (!iack && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("iack_seen", iack, 1);
        if (!iack) return;
        @(posedge clk);
        for (int unsigned i = 0; i < n; i++) exp_q.push_back(W'(i));
        #1;
        if (!keep) irdy = 1'b0;
        chk("iack_after_xfer", iack, (n == 0) ? irdy : 1'b0);
        @(negedge clk);
        // One-cycle latency: the first value (0) is shown right after the accept.
        chk("ordy_latency", ordy, (n != 0));
        if (n != 0) chk("first_oint", oint, 0);
        else        chk("zero_iack_next", iack, irdy);
    endtask

    task automatic drain(input string tag);
        int unsigned t = 0;
        while ((exp_q.size() != 0 || ordy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_ordy_low"}, ordy, 0);
    endtask

    initial begin
        int unsigned t;
        int unsigned base;

        // Reset: held low for 10 ns while irdy is high, so the iack gating is checked too.
        irdy = 1'b1;
        iint = W'(5);
        #1 rst = 1'b0;
        #1;
        chk("rst_iack", iack, 0);
        chk("rst_ordy", ordy, 0);
        chk("rst_oint", oint, 0);
        irdy = 1'b0;
        #9 rst = 1'b1;
        #1;
        chk("post_rst_ordy", ordy, 0);
        chk("post_rst_oint", oint, 0);
        @(posedge clk);
        #1;

        // Single count of 3.
        base = n_out;
        send(W'(3), 1'b0);
        drain("n3");
        chk("n3_count", n_out - base, 3);

        // Back-pressure: count of 4 with random oack.
        rand_oack = 1'b1;
        base = n_out;
        send(W'(4), 1'b0);
        drain("bp");
        chk("bp_count", n_out - base, 4);
        rand_oack = 1'b0;

        // Zero count, then a count of 2 on the very next cycle.
        base = n_out;
        send(W'(0), 1'b1);
        send(W'(2), 1'b0);
        drain("zero");
        chk("zero_count", n_out - base, 2);

        // Back-to-back counts with irdy held high.
        base = n_out;
        send(W'(1), 1'b1);
        send(W'(5), 1'b1);
        send(W'(2), 1'b0);
        drain("b2b");
        chk("b2b_count", n_out - base, 8);

        // Maximum count.
        base = n_out;
        send(W'(2047), 1'b0);
        drain("max");
        chk("max_count", n_out - base, 2047);
        chk("max_last_oint", oint, 2046);

        // Asynchronous reset while a sequence is running.
        send(W'(10), 1'b0);
        t = 0;
        while (exp_q.size() > 5 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("mid_reached_4", exp_q.size(), 5);
        @(posedge clk);
        #2;
        irdy = 1'b1;
        iint = W'(7);
        rst  = 1'b0;
        #1;
        chk("mid_rst_ordy", ordy, 0);
        chk("mid_rst_oint", oint, 0);
        chk("mid_rst_iack", iack, 0);
        exp_q.delete();
        irdy = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_idle_ordy", ordy, 0);
        base = n_out;
        send(W'(2), 1'b0);
        drain("after_rst");
        chk("after_rst_count", n_out - base, 2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnt_dut.md
Name: cnt_dut

Overview:
- Handshaked sequence generator for the counter simulation.
- Accepts one 11-bit count N on an input ready/ack channel.
- Emits the sequence 0, 1, …, N-1 one value per transfer on an output ready/ack channel, then accepts the next count.
- Sits between a stimulus source (input channel) and a consumer that may apply back-pressure (output channel).

Parameters:
- WIDTH, 11, bit width of iint, oint and the internal counter/limit registers.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- irdy  input  1  input valid: iint holds a count.
- iack  output  1  input accept; a transfer occurs on a clk edge where irdy && iack.
- iint  input  WIDTH  count N; sampled only on an input transfer.
- ordy  output  1  output valid: oint holds a sequence value.
- oack  input  1  output accept; a transfer occurs on a clk edge where ordy && oack.
- oint  output  WIDTH  current sequence value.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-low.
  - rst=0 immediately forces state=IDLE, cnt=0, limit=0, ordy=0, oint=0.
  - Any sequence in progress is aborted and discarded.
  - iack=0 while rst=0.
- State machine, two states:
  - IDLE: ordy=0. iack = irdy (combinational, no dependence on oack).
  - RUN: iack=0. ordy=1. oint=cnt (registered).
- IDLE with an input transfer (irdy=1 at edge):
  - Latch limit=iint and cnt=0.
  - If iint!=0, go to RUN; ordy rises in the cycle after the transfer (1-cycle latency).
  - If iint==0, stay IDLE. No output is produced and the next count can be accepted the following cycle.
- RUN with an output transfer (oack=1 at edge):
  - If cnt==limit-1, go to IDLE. ordy falls the next cycle; iack may assert that same next cycle.
  - Otherwise cnt=cnt+1; the new value is presented the next cycle.
- RUN with oack=0: hold cnt, oint and ordy stable (back-pressure, unlimited stall).
- ordy must never depend combinationally on oack; the consumer drives oack from ordy.
- oack while ordy=0 is ignored. irdy while in RUN is ignored; the source keeps irdy and iint stable until iack.
- No overlap: input and output transfers never occur in the same cycle.
- Width/arithmetic: unsigned WIDTH-bit arithmetic, no wrap.
  - The maximum N is 2^WIDTH-1 = 2047, which produces 0..2046.
  - cnt never exceeds limit-1.
- Exactly N output transfers per accepted N; values are strictly increasing by 1 starting from 0.
- Reset asserted mid-RUN: return to IDLE; after release, the first action is a fresh input acceptance.
- Implementation: separate control FSM, counter datapath and handshake logic. Optional assertion: ordy stable and oint stable while ordy && !oack.

Test Plan:
- Reset then single count: rst low 10 ns, then release. Send N=3 with oack always high → iack pulses once; oint=0,1,2 on consecutive cycles starting 1 cycle after acceptance; ordy then falls and iack is available again.
- Back-pressure: N=4 with oack toggled randomly (ordy && random) → exactly 4 transfers with values 0,1,2,3. oint/ordy stable on stall cycles; no duplicates or skips.
- Zero count: N=0, then N=2 → no ordy for N=0; next accept in the following cycle; output 0,1.
- Back-to-back counts: N=1, 5, 2 with irdy held continuously → outputs 0 | 0..4 | 0,1. iack never asserts while ordy=1.
- Maximum count: N=2047 with oack=1 → 2047 transfers ending at oint=2046; no overflow; return to IDLE.
- Reset mid-sequence: N=10; assert rst after oint=4 transferred → ordy=0 and oint=0 immediately (asynchronous). After release, N=2 → output 0,1 only.
